// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - debounced MODE/INC time-setting FSM with BCD load strobe and blink mask
// Optional auto-repeat of a held INC button is enabled by defining AUTO_REPEAT_EN.
module time_set_ctrl #(
    parameter logic [25:0] DEBOUNCE_CYC = 26'd269999,
    parameter logic [25:0] BLINK_HALF   = 26'd13499999,
    parameter logic [25:0] REPEAT_DELAY = 26'd13499999,
    parameter logic [25:0] REPEAT_RATE  = 26'd2699999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       btn_mode_n,
    input  logic       btn_inc_n,
    input  logic [3:0] cur_hrs_1,
    input  logic [3:0] cur_hrs_0,
    input  logic [3:0] cur_min_1,
    input  logic [3:0] cur_min_0,
    output logic [3:0] set_hrs_1,
    output logic [3:0] set_hrs_0,
    output logic [3:0] set_min_1,
    output logic [3:0] set_min_0,
    output logic       time_load,
    output logic       set_active,
    output logic [3:0] blank_mask
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HRS = 2'd1,
        SET_MIN = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  sync1, sync2, deb, deb_d, press;
    logic [25:0] db_cnt [2];
    logic [25:0] blink_cnt;
    logic        blink_phase;
    logic        mode_press, inc_press, inc_evt, rep_evt;

    // Index 0 = MODE, index 1 = INC; all levels are active-low.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1     <= 2'b11;
            sync2     <= 2'b11;
            deb       <= 2'b11;
            deb_d     <= 2'b11;
            press     <= 2'b00;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1 <= {btn_inc_n, btn_mode_n};
            sync2 <= sync1;
            deb_d <= deb;
            press <= deb_d & ~deb;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (db_cnt[i] == DEBOUNCE_CYC) begin
                        deb[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 26'd1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign mode_press = press[0];
    assign inc_press  = press[1];

`ifdef AUTO_REPEAT_EN
    logic [25:0] rep_cnt;
    logic        rep_first;

    assign rep_evt = !deb[1] && (state != RUN) && !inc_press &&
                     (rep_cnt == (rep_first ? REPEAT_DELAY : REPEAT_RATE));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (deb[1] || (state == RUN) || mode_press || inc_press) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (rep_evt) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
        end else begin
            rep_cnt <= rep_cnt + 26'd1;
        end
    end
`else
    // Repeat disabled; the REPEAT_* parameters stay on the interface so instances are uniform.
    assign rep_evt = 1'b0 & (|{REPEAT_DELAY, REPEAT_RATE});
`endif

    assign inc_evt = inc_press | rep_evt;

    function automatic logic hrs_valid(input logic [3:0] t, input logic [3:0] u);
        return ((t < 4'd2) && (u <= 4'd9)) || ((t == 4'd2) && (u <= 4'd3));
    endfunction

    function automatic logic min_valid(input logic [3:0] t, input logic [3:0] u);
        return (t <= 4'd5) && (u <= 4'd9);
    endfunction

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= RUN;
            set_hrs_1   <= '0;
            set_hrs_0   <= '0;
            set_min_1   <= '0;
            set_min_0   <= '0;
            time_load   <= 1'b0;
            set_active  <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            time_load <= 1'b0;
            if (blink_cnt == BLINK_HALF) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 26'd1;
            end

            case (state)
                RUN: begin
                    if (mode_press) begin
                        if (hrs_valid(cur_hrs_1, cur_hrs_0)) begin
                            set_hrs_1 <= cur_hrs_1;
                            set_hrs_0 <= cur_hrs_0;
                        end else begin
                            set_hrs_1 <= '0;
                            set_hrs_0 <= '0;
                        end
                        if (min_valid(cur_min_1, cur_min_0)) begin
                            set_min_1 <= cur_min_1;
                            set_min_0 <= cur_min_0;
                        end else begin
                            set_min_1 <= '0;
                            set_min_0 <= '0;
                        end
                        state       <= SET_HRS;
                        set_active  <= 1'b1;
                        blink_cnt   <= '0;
                        blink_phase <= 1'b0;
                    end
                end
                SET_HRS: begin
                    if (mode_press) begin
                        state       <= SET_MIN;
                        blink_cnt   <= '0;
                        blink_phase <= 1'b0;
                    end else if (inc_evt) begin
                        if (set_hrs_1 == 4'd2 && set_hrs_0 == 4'd3) begin
                            set_hrs_1 <= '0;
                            set_hrs_0 <= '0;
                        end else if (set_hrs_0 == 4'd9) begin
                            set_hrs_1 <= set_hrs_1 + 4'd1;
                            set_hrs_0 <= '0;
                        end else begin
                            set_hrs_0 <= set_hrs_0 + 4'd1;
                        end
                        blink_cnt   <= '0;
                        blink_phase <= 1'b0;
                    end
                end
                SET_MIN: begin
                    if (mode_press) begin
                        state      <= RUN;
                        set_active <= 1'b0;
                        time_load  <= 1'b1;
                    end else if (inc_evt) begin
                        if (set_min_1 == 4'd5 && set_min_0 == 4'd9) begin
                            set_min_1 <= '0;
                            set_min_0 <= '0;
                        end else if (set_min_0 == 4'd9) begin
                            set_min_1 <= set_min_1 + 4'd1;
                            set_min_0 <= '0;
                        end else begin
                            set_min_0 <= set_min_0 + 4'd1;
                        end
                        blink_cnt   <= '0;
                        blink_phase <= 1'b0;
                    end
                end
                default: begin
                    state      <= RUN;
                    set_active <= 1'b0;
                end
            endcase
        end
    end

    // Pure decode of two flops, so the mask is clean in the same cycle the state changes.
    always_comb begin
        blank_mask = 4'b0000;
        if (blink_phase) begin
            if (state == SET_HRS)
                blank_mask = 4'b1100;
            else if (state == SET_MIN)
                blank_mask = 4'b0011;
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - directed self-checking bench for time_set_ctrl
module tb_time_set_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       btn_mode_n = 1'b1;
    logic       btn_inc_n = 1'b1;
    logic [3:0] cur_hrs_1 = '0, cur_hrs_0 = '0, cur_min_1 = '0, cur_min_0 = '0;
    logic [3:0] set_hrs_1, set_hrs_0, set_min_1, set_min_0;
    logic       time_load, set_active;
    logic [3:0] blank_mask;
    logic [15:0] setv;

    int total = 0;
    int bad = 0;
    int load_seen = 0;

    time_set_ctrl #(
        .DEBOUNCE_CYC(26'd3),
        .BLINK_HALF  (26'd7),
        .REPEAT_DELAY(26'd15),
        .REPEAT_RATE (26'd4)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .btn_mode_n(btn_mode_n),
        .btn_inc_n (btn_inc_n),
        .cur_hrs_1 (cur_hrs_1),
        .cur_hrs_0 (cur_hrs_0),
        .cur_min_1 (cur_min_1),
        .cur_min_0 (cur_min_0),
        .set_hrs_1 (set_hrs_1),
        .set_hrs_0 (set_hrs_0),
        .set_min_1 (set_min_1),
        .set_min_0 (set_min_0),
        .time_load (time_load),
        .set_active(set_active),
        .blank_mask(blank_mask)
    );

    assign setv = {set_hrs_1, set_hrs_0, set_min_1, set_min_0};

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) if (time_load === 1'b1) load_seen++;

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        btn_mode_n = 1'b1;
        btn_inc_n  = 1'b1;
        sys_rst_n  = 1'b0;
        step(3);
        sys_rst_n = 1'b1;
        step(2);
    endtask

    task automatic set_cur(input logic [15:0] v);
        {cur_hrs_1, cur_hrs_0, cur_min_1, cur_min_0} = v;
    endtask

    task automatic push(input bit mode, input bit inc, input int lo, input int hi);
        if (mode) btn_mode_n = 1'b0;
        if (inc)  btn_inc_n  = 1'b0;
        step(lo);
        btn_mode_n = 1'b1;
        btn_inc_n  = 1'b1;
        step(hi);
    endtask

    task automatic test_reset();
        set_cur(16'h1234);
        btn_mode_n = 1'b1;
        btn_inc_n  = 1'b1;
        sys_rst_n  = 1'b0;
        @(negedge sys_clk);
        total++;
        if (setv !== 16'h0000) begin bad++; $display("FAIL reset_set: got %h want 0000", setv); end
        total++;
        if ({time_load, set_active, blank_mask} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl: load=%b active=%b mask=%b want 0 0 0000", time_load, set_active, blank_mask);
        end
        step(1);
        sys_rst_n = 1'b1;
        step(20);
        total++;
        if (set_active !== 1'b0 || blank_mask !== 4'b0000) begin
            bad++; $display("FAIL reset_idle: active=%b mask=%b want 0 0000", set_active, blank_mask);
        end
    endtask

    task automatic test_glitch();
        int l0;
        l0 = load_seen;
        set_cur(16'h1234);
        btn_mode_n = 1'b0;
        step(2);
        btn_mode_n = 1'b1;
        step(20);
        total++;
        if (set_active !== 1'b0 || setv !== 16'h0000 || load_seen != l0) begin
            bad++; $display("FAIL glitch: active=%b set=%h loads=%0d want 0 0000 0", set_active, setv, load_seen - l0);
        end
    endtask

    task automatic test_enter_set();
        int lat, errs;
        logic [3:0] exp_mask;
        lat = 0;
        errs = 0;
        do_reset();
        set_cur(16'h1347);
        btn_mode_n = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge sys_clk);
            if (set_active === 1'b1) begin lat = i; break; end
        end
        total++;
        if (lat != 9) begin bad++; $display("FAIL enter_latency: got %0d cycles want 9", lat); end
        total++;
        if (setv !== 16'h1347) begin bad++; $display("FAIL enter_capture: got %h want 1347", setv); end
        for (int k = 0; k < 24; k++) begin
            if (k > 0) @(negedge sys_clk);
            exp_mask = (((k / 8) % 2) == 1) ? 4'b1100 : 4'b0000;
            if (blank_mask !== exp_mask) errs++;
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL blink_hrs: %0d of 24 samples wrong, want 0", errs); end
        step(1);
        btn_mode_n = 1'b1;
        step(15);
        total++;
        if (set_active !== 1'b1 || setv !== 16'h1347) begin
            bad++; $display("FAIL mode_hold_once: active=%b set=%h want 1 1347", set_active, setv);
        end
    endtask

    task automatic test_edit_wrap();
        int found;
        do_reset();
        set_cur(16'h2258);
        push(1, 0, 12, 12);
        total++;
        if (setv !== 16'h2258) begin bad++; $display("FAIL wrap_enter: got %h want 2258", setv); end
        found = 0;
        btn_inc_n = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge sys_clk);
            if (set_hrs_0 !== 4'd2) begin found = 1; break; end
        end
        total++;
        if (found == 0 || setv !== 16'h2358 || blank_mask !== 4'b0000) begin
            bad++; $display("FAIL hrs_inc_visible: set=%h mask=%b want 2358 0000", setv, blank_mask);
        end
        step(1);
        btn_inc_n = 1'b1;
        step(12);
        push(0, 1, 12, 12);
        total++;
        if (setv !== 16'h0058) begin bad++; $display("FAIL hrs_wrap: got %h want 0058", setv); end
        push(1, 0, 12, 12);
        push(0, 1, 12, 12);
        total++;
        if (setv !== 16'h0059) begin bad++; $display("FAIL min_inc: got %h want 0059", setv); end
        push(0, 1, 12, 12);
        total++;
        if (setv !== 16'h0000 || set_active !== 1'b1) begin
            bad++; $display("FAIL min_wrap: set=%h active=%b want 0000 1", setv, set_active);
        end
    endtask

    task automatic test_load();
        int l0, n;
        logic [21:0] at_load;
        l0 = load_seen;
        n = 0;
        at_load = '1;
        btn_mode_n = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            if (time_load === 1'b1) begin
                n++;
                at_load = {set_active, blank_mask, setv, 1'b1};
            end
        end
        step(1);
        btn_mode_n = 1'b1;
        step(12);
        total++;
        if (n != 1) begin bad++; $display("FAIL load_width: got %0d cycles want 1", n); end
        total++;
        if (at_load !== {1'b0, 4'b0000, 16'h0000, 1'b1}) begin
            bad++; $display("FAIL load_cycle: active/mask/set/seen=%h want 000001", at_load);
        end
        set_cur(16'h0915);
        step(20);
        total++;
        if (setv !== 16'h0000 || set_active !== 1'b0 || blank_mask !== 4'b0000 || load_seen != l0 + 1) begin
            bad++; $display("FAIL load_hold: set=%h active=%b mask=%b loads=%0d want 0000 0 0000 1",
                            setv, set_active, blank_mask, load_seen - l0);
        end
        push(0, 1, 12, 12);
        total++;
        if (setv !== 16'h0000 || set_active !== 1'b0) begin
            bad++; $display("FAIL run_inc_ignored: set=%h active=%b want 0000 0", setv, set_active);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        set_cur(16'h0530);
        push(1, 0, 12, 12);
        push(1, 1, 12, 12);
        total++;
        if (setv !== 16'h0530 || set_active !== 1'b1) begin
            bad++; $display("FAIL mode_wins: set=%h active=%b want 0530 1", setv, set_active);
        end
        push(0, 1, 12, 12);
        total++;
        if (setv !== 16'h0531) begin bad++; $display("FAIL now_set_min: got %h want 0531", setv); end
    endtask

    task automatic test_clamp();
        do_reset();
        set_cur(16'h2461);
        push(1, 0, 12, 12);
        total++;
        if (setv !== 16'h0000) begin bad++; $display("FAIL clamp_range: got %h want 0000", setv); end
        do_reset();
        set_cur(16'h1A5A);
        push(1, 0, 12, 12);
        total++;
        if (setv !== 16'h0000) begin bad++; $display("FAIL clamp_bcd: got %h want 0000", setv); end
    endtask

    task automatic test_reset_mid_edit();
        int l0;
        do_reset();
        set_cur(16'h2359);
        push(1, 0, 12, 12);
        total++;
        if (setv !== 16'h2359) begin bad++; $display("FAIL capture_max: got %h want 2359", setv); end
        push(0, 1, 12, 12);
        push(1, 0, 12, 12);
        l0 = load_seen;
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        total++;
        if (setv !== 16'h0000 || set_active !== 1'b0 || blank_mask !== 4'b0000) begin
            bad++; $display("FAIL mid_reset: set=%h active=%b mask=%b want 0000 0 0000", setv, set_active, blank_mask);
        end
        step(1);
        sys_rst_n = 1'b1;
        step(20);
        total++;
        if (load_seen != l0 || set_active !== 1'b0) begin
            bad++; $display("FAIL mid_reset_quiet: loads=%0d active=%b want 0 0", load_seen - l0, set_active);
        end
    endtask

    task automatic test_hold_inc();
        int chg[$];
        int h, found;
        logic [3:0] prev;
`ifdef AUTO_REPEAT_EN
        int exp_h[6] = '{1, 17, 22, 27, 32, 37};
        logic [3:0] exp_final = 4'd6;
`else
        int exp_h[1] = '{1};
        logic [3:0] exp_final = 4'd1;
`endif
        found = 0;
        do_reset();
        set_cur(16'h0000);
        push(1, 0, 12, 12);
        btn_inc_n = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge sys_clk);
            if (set_hrs_0 !== 4'd0) begin found = 1; break; end
        end
        total++;
        if (found == 0) begin bad++; $display("FAIL hold_first: no increment within 30 cycles"); end
        chg.push_back(1);
        prev = set_hrs_0;
        for (h = 2; h <= 50; h++) begin
            @(negedge sys_clk);
            if (set_hrs_0 !== prev) chg.push_back(h);
            prev = set_hrs_0;
            if (h == 34) btn_inc_n = 1'b1;
        end
        step(10);
        total++;
        if (chg.size() != $size(exp_h)) begin
            bad++; $display("FAIL hold_count: got %0d increments want %0d", chg.size(), $size(exp_h));
        end else begin
            for (int j = 0; j < $size(exp_h); j++) begin
                total++;
                if (chg[j] != exp_h[j]) begin
                    bad++; $display("FAIL hold_at_%0d: got cycle %0d want %0d", j, chg[j], exp_h[j]);
                end
            end
        end
        total++;
        if (set_hrs_0 !== exp_final || set_hrs_1 !== 4'd0) begin
            bad++; $display("FAIL hold_final: got %h%h want 0%h", set_hrs_1, set_hrs_0, exp_final);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_enter_set();
        test_edit_wrap();
        test_load();
        test_same_cycle();
        test_clamp();
        test_reset_mid_edit();
        test_hold_inc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
